instr_prefetch: RTL and testbench
=================================

// Module: instr_prefetch
// PURPOSE
//  Instruction-byte prefetch queue directly upstream of the Cpu decode step. Issues sequential
//  byte reads from fetchPc on the shared memory bus, buffers returned bytes with their address,
//  and presents them to the decoder over a valid/ready handshake. A redirect (jump, call, ret,
//  halt) flushes the queue and restarts fetch at a new address.
// PARAMETERS
//  DEPTH     4        queue entries (power of two, >=2)
//  RESET_PC  16'h0000 fetch address loaded on reset
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  reset       in   1   synchronous, active-high
//  redirect    in   1   flush queue, restart fetch at redirectPc (one-cycle pulse)
//  redirectPc  in   16  new fetch address, sampled when redirect=1
//  memGrant    in   1   bus free for instruction fetch this cycle (low while Cpu does data I/O)
//  memRead     out  1   fetch request this cycle (accepted only if memGrant=1)
//  memAddress  out  16  fetch byte address, valid when memRead=1
//  memDataIn   in   8   read data; valid the cycle after an accepted request
//  outValid    out  1   queue head holds a byte
//  outReady    in   1   decoder consumes head when outValid&outReady
//  outByte     out  8   head byte
//  outPc       out  16  address of head byte
//  level       out  3   entries currently queued (0..DEPTH); width $clog2(DEPTH)+1
// BEHAVIOUR
//  Reset: fetchPc=RESET_PC, queue empty, pending cleared; outValid=0, outByte=0, outPc=0,
//   level=0, memRead=0 during reset cycles. Reset mid-operation discards everything incl. in-flight.
//  Accepted request: memRead&memGrant in cycle N -> pendValid=1, pendPc=memAddress at edge of N;
//   memDataIn sampled in N+1 and pushed as {byte,pendPc} at edge ending N+1. One request per cycle.
//  Issue rule: memRead = !reset && (level + pendValid) < DEPTH, or redirect=1 (queue treated empty).
//   memRead never depends on memGrant (no combinational loop). fetchPc increments only on accept.
//  memAddress = redirect ? redirectPc : fetchPc (redirect bypass, no bubble).
//  fetchPc wraps 16'hFFFF -> 16'h0000 silently; outPc follows the same wrap.
//  Pop: outValid&outReady -> head removed at edge; outByte/outPc show next entry next cycle.
//  Push and pop same cycle: level unchanged; with level=DEPTH a pop frees the slot but issue
//   decision uses registered level, so no overflow is possible (credit covers in-flight byte).
//  Empty: outValid=0; outByte/outPc hold last values (don't-care for checker).
//  Redirect in cycle R: queue flushed and level=0 at edge of R; byte returning in R (request of
//   R-1) discarded; pop in R ignored; fetchPc=redirectPc+(accepted?1:0). If memGrant=1 in R,
//   first new byte enqueued at edge of R+1, outValid=1 in R+2.
//  Latency: first cycle after reset with memGrant=1 = cycle 0 -> outValid=1 in cycle 2.
//  memGrant=0: request not accepted, fetchPc holds, memRead/memAddress may stay asserted.
//  Throughput: with memGrant=1 and outReady=1 continuously, one byte per cycle sustained.
// STRUCTURE
//  Shared package cpu_pkg: OP_* opcodes, IO_NONE/IO_READ/IO_WRITE, ADDR_W=16, DATA_W=8,
//   typedef fetch_entry_t {logic [7:0] byte; logic [15:0] pc;}.
//  Sub-module prefetch_fifo: sync FIFO of fetch_entry_t, DEPTH entries, push/pop/flush, count
//   output, wrapping pointers with extra bit. instr_prefetch holds fetchPc, pendValid/pendPc,
//   issue/credit logic.
// TESTING
//  1 Reset release, memGrant=1, outReady=0, ROM 00:E0 01:E0 02:E1 -> memAddress 0,1,2,3 then
//    memRead=0 at level=4; outValid in cycle 2, outByte=E0 outPc=0000.
//  2 outReady=1 steady -> bytes E0,E0,E1 at outPc 0000,0001,0002 on consecutive cycles, level<=1.
//  3 redirect=1 redirectPc=0002 while level=3 and a read in flight -> stale byte dropped, level=0,
//    memAddress=0002 same cycle, next output outPc=0002 byte=E1 two cycles later.
//  4 memGrant=0 for 3 cycles mid-stream -> fetchPc frozen, no duplicate/missing outPc values.
//  5 redirectPc=FFFE, ROM FFFE:11 FFFF:22 0000:E0 -> outPc FFFE,FFFF,0000 in order, bytes 11,22,E0.
//  6 reset asserted with level=3 and read in flight -> next cycle outValid=0 level=0; refetch
//    from RESET_PC; random outReady/memGrant run against scoreboard: no loss, no reorder.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, opcode and I/O encodings, and the prefetch queue entry.
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_LDI  = 8'h10,
        OP_ADD  = 8'h20,
        OP_IN   = 8'h30,
        OP_OUT  = 8'h31,
        OP_JMP  = 8'hE0,
        OP_CALL = 8'hE1,
        OP_RET  = 8'hE2,
        OP_HALT = 8'hFF
    } opcode_e;

    typedef enum logic [1:0] {
        IO_NONE  = 2'd0,
        IO_READ  = 2'd1,
        IO_WRITE = 2'd2
    } io_op_e;

    // 'byte' is a reserved word, so the instruction byte field is called data.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic is_redirect_op(input logic [7:0] op);
        return (op == OP_JMP) || (op == OP_CALL) || (op == OP_RET) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of fetch entries; pointers carry one extra bit so full and empty differ.
module prefetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     entries_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            entries_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
        end
    end

    assign head  = entries_q[rd_ptr_q[PTR_W-1:0]];
    assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction-byte prefetch queue: issues sequential byte reads, buffers returned bytes with
// their address, and hands them to the decoder; a redirect flushes and restarts fetch.
module instr_prefetch
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    localparam int               CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectPc,
    input  logic              memGrant,
    output logic              memRead,
    output logic [ADDR_W-1:0] memAddress,
    input  logic [DATA_W-1:0] memDataIn,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outByte,
    output logic [ADDR_W-1:0] outPc,
    output logic [CNT_W-1:0]  level
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    committed;
    logic              credit_ok;
    logic              accept;
    logic              push;
    logic              pop;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    // Credit counts queued plus in-flight bytes, so a returning byte always has a slot.
    always_comb begin
        committed    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_valid_q};
        credit_ok    = committed < (CNT_W + 1)'(DEPTH);
        memRead      = !reset && (redirect || credit_ok);
        memAddress   = redirect ? redirectPc : fetch_pc_q;
        accept       = memRead && memGrant;
        fetch_pc_d   = accept ? memAddress + ADDR_W'(1) : memAddress;
        pend_valid_d = accept;
        pend_pc_d    = memAddress;
        push         = pend_valid_q && !redirect;
        pop          = outValid && outReady && !redirect;
        push_entry   = '{data: memDataIn, pc: pend_pc_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            pend_valid_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_pc_q <= pend_pc_d;
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .count      (fifo_count)
    );

    // Outputs read as idle/zero while reset is held, even before the first reset edge.
    always_comb begin
        outValid = !reset && (fifo_count != '0);
        level    = reset ? '0 : fifo_count;
        outByte  = reset ? '0 : head.data;
        outPc    = reset ? '0 : head.pc;
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: directed scenarios plus a randomized run, with a byte-stream
// scoreboard built from a ROM image and the sequential-fetch rule.
module tb_instr_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [15:0] redirectPc;
    logic        memGrant;
    logic        memRead;
    logic [15:0] memAddress;
    logic [7:0]  memDataIn = 8'h00;
    logic        outValid;
    logic        outReady;
    logic [7:0]  outByte;
    logic [15:0] outPc;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [0:65535];

    typedef struct {
        logic [7:0]  b;
        logic [15:0] pc;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    instr_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .memGrant   (memGrant),
        .memRead    (memRead),
        .memAddress (memAddress),
        .memDataIn  (memDataIn),
        .outValid   (outValid),
        .outReady   (outReady),
        .outByte    (outByte),
        .outPc      (outPc),
        .level      (level)
    );

    // Memory: data for an accepted request appears during the following cycle.
    always @(posedge clk) begin
        memDataIn <= (memRead && memGrant) ? rom[memAddress] : 8'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected decoder stream after a restart at pc: consecutive addresses, 16-bit wrap.
    task automatic start_stream(input logic [15:0] pc);
        logic [15:0] a;
        sbq.delete();
        for (int i = 0; i < 64; i++) begin
            a = pc + 16'(i);
            sbq.push_back('{b: rom[a], pc: a});
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("valid_vs_level", {31'd0, outValid}, {31'd0, level != 3'd0});
            chk("level_bound", {31'd0, level <= 3'(DEPTH)}, 32'd1);
        end
        if (!reset && !redirect && outValid && outReady) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got pc %0h, expected no output", outPc);
            end else begin
                e = sbq.pop_front();
                chk("pop_pc", {16'd0, outPc}, {16'd0, e.pc});
                chk("pop_byte", {24'd0, outByte}, {24'd0, e.b});
            end
        end
    end

    task automatic hold_reset(input int n);
        reset    = 1'b1;
        redirect = 1'b0;
        start_stream(RESET_PC);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_valid", {31'd0, outValid}, 32'd0);
            chk("rst_level", {29'd0, level}, 32'd0);
            chk("rst_memread", {31'd0, memRead}, 32'd0);
            chk("rst_byte", {24'd0, outByte}, 32'd0);
            chk("rst_pc", {16'd0, outPc}, 32'd0);
            next();
        end
    endtask

    initial begin
        logic [15:0] exp_addr;
        int seg;
        int r;

        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        rom[16'h0000] = 8'hE0;
        rom[16'h0001] = 8'hE0;
        rom[16'h0002] = 8'hE1;
        rom[16'hFFFE] = 8'h11;
        rom[16'hFFFF] = 8'h22;

        reset = 1'b1; redirect = 1'b0; redirectPc = 16'h0000;
        memGrant = 1'b0; outReady = 1'b0;
        next();

        // Fill from reset with the decoder stalled.
        hold_reset(2);
        reset = 1'b0; memGrant = 1'b1; outReady = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                chk("t1_memread", {31'd0, memRead}, 32'd1);
                chk("t1_addr", {16'd0, memAddress}, 32'(c));
            end
            if (c < 2) chk("t1_early_valid", {31'd0, outValid}, 32'd0);
            if (c == 2) begin
                chk("t1_valid", {31'd0, outValid}, 32'd1);
                chk("t1_byte", {24'd0, outByte}, 32'hE0);
                chk("t1_pc", {16'd0, outPc}, 32'h0000);
            end
            if (c >= 4) chk("t1_full_stop", {31'd0, memRead}, 32'd0);
            if (c == 5) chk("t1_level", {29'd0, level}, 32'd4);
            next();
        end

        // Streaming from reset with the decoder always ready.
        hold_reset(1);
        reset = 1'b0; memGrant = 1'b1; outReady = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c >= 2) chk("t2_valid", {31'd0, outValid}, 32'd1);
            chk("t2_level", {31'd0, level <= 3'd1}, 32'd1);
            if (c == 2) chk("t2_byte0", {24'd0, outByte}, 32'hE0);
            if (c == 3) chk("t2_pc1", {16'd0, outPc}, 32'h0001);
            if (c == 4) begin
                chk("t2_byte2", {24'd0, outByte}, 32'hE1);
                chk("t2_pc2", {16'd0, outPc}, 32'h0002);
            end
            next();
        end

        // Redirect with three queued bytes and one in flight.
        hold_reset(1);
        reset = 1'b0; memGrant = 1'b1; outReady = 1'b0;
        repeat (4) next();
        redirect = 1'b1; redirectPc = 16'h0002;
        start_stream(16'h0002);
        @(negedge clk);
        chk("t3_level_before", {29'd0, level}, 32'd3);
        chk("t3_memread", {31'd0, memRead}, 32'd1);
        chk("t3_bypass_addr", {16'd0, memAddress}, 32'h0002);
        next();
        redirect = 1'b0;
        exp_addr = 16'h0003;
        @(negedge clk);
        chk("t3_flushed_level", {29'd0, level}, 32'd0);
        chk("t3_flushed_valid", {31'd0, outValid}, 32'd0);
        chk("t3_addr_after", {16'd0, memAddress}, {16'd0, exp_addr});
        exp_addr++;
        next();
        outReady = 1'b1;
        @(negedge clk);
        chk("t3_valid", {31'd0, outValid}, 32'd1);
        chk("t3_pc", {16'd0, outPc}, 32'h0002);
        chk("t3_byte", {24'd0, outByte}, 32'hE1);
        chk("t3_addr_stream", {16'd0, memAddress}, {16'd0, exp_addr});
        exp_addr++;
        for (int c = 0; c < 6; c++) begin
            next();
            @(negedge clk);
            chk("t3_addr_stream", {16'd0, memAddress}, {16'd0, exp_addr});
            exp_addr++;
        end

        // Bus taken away for three cycles mid-stream.
        next();
        memGrant = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_addr_frozen", {16'd0, memAddress}, {16'd0, exp_addr});
            next();
        end
        memGrant = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t4_addr_resume", {16'd0, memAddress}, {16'd0, exp_addr});
            exp_addr++;
            next();
        end

        // Redirect across the top of the address space.
        redirect = 1'b1; redirectPc = 16'hFFFE; outReady = 1'b1; memGrant = 1'b1;
        start_stream(16'hFFFE);
        next();
        redirect = 1'b0;
        next();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_valid", {31'd0, outValid}, 32'd1);
            case (c)
                0: begin chk("t5_pc", {16'd0, outPc}, 32'hFFFE); chk("t5_byte", {24'd0, outByte}, 32'h11); end
                1: begin chk("t5_pc", {16'd0, outPc}, 32'hFFFF); chk("t5_byte", {24'd0, outByte}, 32'h22); end
                default: begin chk("t5_pc", {16'd0, outPc}, 32'h0000); chk("t5_byte", {24'd0, outByte}, 32'hE0); end
            endcase
            next();
        end

        // Reset mid-operation with a read in flight.
        hold_reset(1);
        reset = 1'b0; memGrant = 1'b1; outReady = 1'b0;
        repeat (4) next();
        reset = 1'b1;
        start_stream(RESET_PC);
        @(negedge clk);
        chk("t6_rst_valid", {31'd0, outValid}, 32'd0);
        chk("t6_rst_level", {29'd0, level}, 32'd0);
        next();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_level", {29'd0, level}, 32'd0);
        chk("t6_valid", {31'd0, outValid}, 32'd0);
        chk("t6_refetch", {16'd0, memAddress}, {16'd0, RESET_PC});
        next();
        next();
        @(negedge clk);
        chk("t6_first_pc", {16'd0, outPc}, {16'd0, RESET_PC});
        chk("t6_first_byte", {24'd0, outByte}, 32'hE0);
        next();

        // Randomized run against the scoreboard.
        seg = 0;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 99));
            redirect = 1'b0;
            if (reset) begin
                reset = 1'b0;
                seg = 0;
            end else if (seg >= 50 || r < 3) begin
                redirect   = 1'b1;
                redirectPc = 16'($urandom);
                start_stream(redirectPc);
                seg = 0;
            end else if (r == 3) begin
                reset = 1'b1;
                start_stream(RESET_PC);
                seg = 0;
            end
            memGrant = ($urandom_range(0, 9) < 7);
            outReady = ($urandom_range(0, 9) < 6);
            seg++;
            next();
        end

        reset = 1'b0; redirect = 1'b0; memGrant = 1'b0; outReady = 1'b0;
        next();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
